// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding / load-use hazard unit that sits beside decode.
// A shift scoreboard holds {valid, rd, is_load} for the last DEPTH issued
// instructions (slot 1 = EX ... slot DEPTH = WB). Each source port picks the
// youngest matching producer. A match on a load that is too young raises a
// stall instead of a forward.
module fwd_hazard_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          issue_valid,
    input  logic                          issue_we,
    input  logic                          issue_is_load,
    input  logic [REG_ADDR_W-1:0]         issue_rd,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
    input  logic [NUM_SRC-1:0]            src_used,
    input  logic                          hold,
    input  logic                          flush,
    output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
    output logic                          stall,
    output logic [CNT_W-1:0]              stall_cnt
);

    // Scoreboard slots, index 1 is the youngest in-flight instruction.
    logic [DEPTH:1]          valid_r;
    logic [DEPTH:1]          load_r;
    logic [REG_ADDR_W-1:0]   rd_r [1:DEPTH];
    logic [CNT_W-1:0]        stall_cnt_r;

    logic [NUM_SRC*SEL_W-1:0] fwd_sel_s;
    logic [NUM_SRC-1:0]       hazard_s;
    logic                     stall_s;
    logic                     issue_take_s;

    // Per-port youngest-producer search. A young load wins the search but
    // yields a hazard, so an older producer behind it is never used.
    always_comb begin
        logic                  found_v;
        logic [REG_ADDR_W-1:0] src_v;
        fwd_sel_s = {(NUM_SRC*SEL_W){1'b0}};
        hazard_s  = {NUM_SRC{1'b0}};
        found_v   = 1'b0;
        src_v     = {REG_ADDR_W{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            found_v = 1'b0;
            src_v   = src_addr[i*REG_ADDR_W +: REG_ADDR_W];
            for (int k = 1; k <= DEPTH; k++) begin
                if (!found_v && src_used[i] && valid_r[k] &&
                    (rd_r[k] == src_v) && (src_v != {REG_ADDR_W{1'b0}})) begin
                    found_v = 1'b1;
                    if (load_r[k] && (k <= LOAD_LAT)) begin
                        hazard_s[i] = 1'b1;
                    end else begin
                        fwd_sel_s[i*SEL_W +: SEL_W] = SEL_W'(k);
                    end
                end else begin
                    found_v = found_v;
                end
            end
        end
    end

    // Stall is the union of port hazards; only real register writers enter
    // the scoreboard, and never while decode is stalled.
    always_comb begin
        stall_s      = |hazard_s;
        issue_take_s = issue_valid && issue_we &&
                       (issue_rd != {REG_ADDR_W{1'b0}}) && !stall_s;
    end

    // Slot shift: flush empties everything, hold freezes, otherwise advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {DEPTH{1'b0}};
            load_r  <= {DEPTH{1'b0}};
            for (int k = 1; k <= DEPTH; k++) begin
                rd_r[k] <= {REG_ADDR_W{1'b0}};
            end
        end else if (flush) begin
            valid_r <= {DEPTH{1'b0}};
            load_r  <= {DEPTH{1'b0}};
        end else if (hold) begin
            valid_r <= valid_r;
            load_r  <= load_r;
        end else begin
            for (int k = DEPTH; k >= 2; k--) begin
                valid_r[k] <= valid_r[k-1];
                load_r[k]  <= load_r[k-1];
                rd_r[k]    <= rd_r[k-1];
            end
            valid_r[1] <= issue_take_s;
            load_r[1]  <= issue_take_s && issue_is_load;
            rd_r[1]    <= issue_rd;
        end
    end

    // Saturating count of stall cycles that actually cost a pipeline step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && !hold && !flush && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign fwd_sel   = fwd_sel_s;
    assign stall     = stall_s;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Self-checking bench for fwd_hazard_scoreboard: directed vector table,
// hand-written reset/hold/flush/saturation sequences, and a randomized run
// checked against a queue-based model of the in-flight instructions.
module tb_fwd_hazard_scoreboard;

    localparam int RW       = 5;
    localparam int NS       = 2;
    localparam int DEPTH    = 3;
    localparam int LOAD_LAT = 1;
    localparam int CW       = 4;
    localparam int SW       = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              issue_valid, issue_we, issue_is_load;
    logic [RW-1:0]     issue_rd;
    logic [NS*RW-1:0]  src_addr;
    logic [NS-1:0]     src_used;
    logic              hold, flush;
    logic [NS*SW-1:0]  fwd_sel;
    logic              stall;
    logic [CW-1:0]     stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    fwd_hazard_scoreboard #(
        .REG_ADDR_W(RW), .NUM_SRC(NS), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_we(issue_we),
        .issue_is_load(issue_is_load), .issue_rd(issue_rd), .src_addr(src_addr),
        .src_used(src_used), .hold(hold), .flush(flush), .fwd_sel(fwd_sel),
        .stall(stall), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v, we, ld;
        logic [4:0] rd, s0, s1;
        logic [1:0] used;
        int         e0, e1;
        logic       es;
        int         ec;
    } row_t;

    typedef struct {
        bit v;
        int rd;
        bit ld;
    } ent_t;

    row_t rows [19];
    ent_t q [$];
    int   m_cnt;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic row_t mk(input logic v, we, ld, input int rd, s0, s1, used,
                                input int e0, e1, input logic es, input int ec);
        row_t r;
        r.v = v; r.we = we; r.ld = ld;
        r.rd = rd[4:0]; r.s0 = s0[4:0]; r.s1 = s1[4:0]; r.used = used[1:0];
        r.e0 = e0; r.e1 = e1; r.es = es; r.ec = ec;
        return r;
    endfunction

    task automatic drive(input logic v, we, ld, input logic [4:0] rd, s0, s1,
                         input logic [1:0] used, input logic h, f);
        issue_valid = v; issue_we = we; issue_is_load = ld; issue_rd = rd;
        src_addr = {s1, s0}; src_used = used; hold = h; flush = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: walk in-flight list youngest first, first real match decides.
    task automatic model_port(input int src, input bit used, output int sel, output bit haz);
        sel = 0;
        haz = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (used && src != 0 && q[k-1].v && q[k-1].rd == src) begin
                if (q[k-1].ld && k <= LOAD_LAT) haz = 1'b1;
                else sel = k;
                break;
            end
        end
    endtask

    task automatic model_clear();
        q.delete();
        for (int k = 0; k < DEPTH; k++) q.push_back('{v: 1'b0, rd: 0, ld: 1'b0});
    endtask

    initial begin
        int   s0e, s1e, ms;
        bit   h0, h1, mstall;
        ent_t e;

        rows[0]  = mk(1,1,0, 5, 0,0,0, 0,0,0,0);
        rows[1]  = mk(0,0,0, 0, 5,0,1, 1,0,0,0);
        rows[2]  = mk(0,0,0, 0, 0,5,2, 0,2,0,0);
        rows[3]  = mk(0,0,0, 0, 5,5,3, 3,3,0,0);
        rows[4]  = mk(0,0,0, 0, 5,0,1, 0,0,0,0);
        rows[5]  = mk(1,1,1, 7, 0,0,0, 0,0,0,0);
        rows[6]  = mk(1,1,0, 9, 7,0,1, 0,0,1,0);
        rows[7]  = mk(1,1,0, 9, 7,0,1, 2,0,0,1);
        rows[8]  = mk(0,0,0, 0, 9,7,3, 1,3,0,1);
        rows[9]  = mk(1,1,0, 0, 0,0,0, 0,0,0,1);
        rows[10] = mk(1,1,0, 3, 0,0,1, 0,0,0,1);
        rows[11] = mk(1,1,0, 3, 3,0,1, 1,0,0,1);
        rows[12] = mk(0,0,0, 0, 3,3,3, 1,1,0,1);
        rows[13] = mk(1,0,0, 4, 0,0,0, 0,0,0,1);
        rows[14] = mk(0,0,0, 0, 4,3,3, 0,3,0,1);
        rows[15] = mk(1,1,0, 6, 0,0,0, 0,0,0,1);
        rows[16] = mk(1,1,1, 6, 0,0,0, 0,0,0,1);
        rows[17] = mk(0,0,0, 0, 6,0,1, 0,0,1,1);
        rows[18] = mk(0,0,0, 0, 6,0,1, 2,0,0,2);

        // Reset state, checked without any clock edge dependence.
        rst_n = 1'b0;
        drive(0,0,0, 5'd0, 5'd5, 5'd5, 2'b11, 0, 0);
        #3;
        chk("reset_sel", int'(fwd_sel), 0);
        chk("reset_stall", int'(stall), 0);
        chk("reset_cnt", int'(stall_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed vector table.
        for (int i = 0; i < 19; i++) begin
            drive(rows[i].v, rows[i].we, rows[i].ld, rows[i].rd, rows[i].s0, rows[i].s1,
                  rows[i].used, 0, 0);
            #2;
            chk($sformatf("row%0d_sel0", i), int'(fwd_sel[SW-1:0]), rows[i].e0);
            chk($sformatf("row%0d_sel1", i), int'(fwd_sel[2*SW-1:SW]), rows[i].e1);
            chk($sformatf("row%0d_stall", i), int'(stall), int'(rows[i].es));
            chk($sformatf("row%0d_cnt", i), int'(stall_cnt), rows[i].ec);
            tick();
        end

        // Asynchronous reset mid-cycle clears forwarding and counter at once.
        drive(1,1,0, 5'd5, 5'd0, 5'd0, 2'b00, 0, 0);
        tick();
        drive(0,0,0, 5'd0, 5'd5, 5'd0, 2'b01, 0, 0);
        #2;
        chk("pre_reset_sel0", int'(fwd_sel[SW-1:0]), 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_sel0", int'(fwd_sel[SW-1:0]), 0);
        chk("async_reset_cnt", int'(stall_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("after_reset_sel0", int'(fwd_sel[SW-1:0]), 0);

        // Hold during a load-use stall, then hold+flush on the same edge.
        drive(1,1,1, 5'd7, 5'd0, 5'd0, 2'b00, 0, 0);
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(1,1,0, 5'd9, 5'd7, 5'd0, 2'b01, 1, 0);
            #2;
            chk("hold_stall", int'(stall), 1);
            chk("hold_cnt", int'(stall_cnt), 0);
            tick();
        end
        drive(1,1,0, 5'd9, 5'd7, 5'd0, 2'b01, 1, 1);
        tick();
        drive(0,0,0, 5'd0, 5'd7, 5'd7, 2'b11, 0, 0);
        #2;
        chk("flush_stall", int'(stall), 0);
        chk("flush_sel", int'(fwd_sel), 0);
        chk("flush_cnt", int'(stall_cnt), 0);
        tick();

        // Counter saturation: 20 separate load-use stalls into a 4-bit counter.
        for (int c = 0; c < 20; c++) begin
            drive(1,1,1, 5'd7, 5'd0, 5'd0, 2'b00, 0, 0);
            tick();
            drive(1,1,0, 5'd8, 5'd7, 5'd0, 2'b01, 0, 0);
            #2;
            if (c == 5) chk("sat_stall", int'(stall), 1);
            if (c == 5) chk("sat_mid_cnt", int'(stall_cnt), 5);
            tick();
        end
        chk("sat_cnt", int'(stall_cnt), 15);
        drive(1,1,1, 5'd7, 5'd0, 5'd0, 2'b00, 0, 0);
        tick();
        drive(1,1,0, 5'd8, 5'd7, 5'd0, 2'b01, 0, 0);
        tick();
        chk("sat_hold_cnt", int'(stall_cnt), 15);

        // Randomized run against the in-flight list model, from a fresh reset.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        model_clear();
        m_cnt = 0;
        tick();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
                  5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
                  2'($urandom_range(0, 3)), $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
            model_port(int'(src_addr[RW-1:0]), src_used[0], s0e, h0);
            model_port(int'(src_addr[2*RW-1:RW]), src_used[1], s1e, h1);
            mstall = h0 | h1;
            #2;
            chk("rnd_sel0", int'(fwd_sel[SW-1:0]), s0e);
            chk("rnd_sel1", int'(fwd_sel[2*SW-1:SW]), s1e);
            chk("rnd_stall", int'(stall), int'(mstall));
            chk("rnd_cnt", int'(stall_cnt), m_cnt);
            if (flush) begin
                model_clear();
            end else if (!hold) begin
                e.v  = issue_valid && issue_we && issue_rd != 0 && !mstall;
                e.rd = int'(issue_rd);
                e.ld = issue_is_load;
                q.push_front(e);
                ms = q.size();
                if (ms > DEPTH) q.pop_back();
                if (mstall && m_cnt < 15) m_cnt++;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
